// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared owner encoding and default parameters for the SRAM arbiter
package sram_arbiter_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - fetch, data and SRAM signal bundle around the arbiter
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_gnt;
    logic                  inst_rvalid;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic [DATA_W/8-1:0]   data_wen;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_gnt;
    logic                  data_rvalid;
    logic [DATA_W-1:0]     data_rdata;

    logic                  sram_en;
    logic [DATA_W/8-1:0]   sram_wen;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;

    modport arb (
        input  inst_req, inst_addr,
        output inst_gnt, inst_rvalid, inst_rdata,
        input  data_req, data_wen, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport cpu (
        output inst_req, inst_addr,
        input  inst_gnt, inst_rvalid, inst_rdata,
        output data_req, data_wen, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport mem (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/sram_arbiter_arb_prio_age.sv
// rtl/sram_arbiter_arb_prio_age.sv - data-first priority with an aging counter that protects fetch
module arb_prio_age
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    output logic inst_sel,
    output logic data_sel
);
    logic [3:0] wait_cnt;
    logic       inst_pri;

    assign inst_pri = (wait_cnt == 4'(MAX_WAIT));

    // Grants are gated by resetn so nothing reaches the SRAM while in reset.
    always_comb begin
        inst_sel = 1'b0;
        data_sel = 1'b0;
        if (resetn) begin
            if (data_req && !(inst_req && inst_pri))
                data_sel = 1'b1;
            else if (inst_req)
                inst_sel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 4'd0;
        end else if (inst_req && !inst_sel) begin
            if (!inst_pri)
                wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one synchronous-read SRAM between instruction fetch and data ports
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk,
    input  logic          resetn,
    sram_arbiter_if.arb   bus
);
    logic              inst_sel;
    logic              data_sel;
    owner_t            resp_owner;
    logic              resp_read;
    logic              inst_rvalid;
    logic              data_rvalid;
    logic [DATA_W-1:0] inst_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;

    arb_prio_age #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk      (clk),
        .resetn   (resetn),
        .inst_req (bus.inst_req),
        .data_req (bus.data_req),
        .inst_sel (inst_sel),
        .data_sel (data_sel)
    );

    assign bus.inst_gnt   = inst_sel;
    assign bus.data_gnt   = data_sel;
    assign bus.sram_en    = inst_sel | data_sel;
    assign bus.sram_wen   = data_sel ? bus.data_wen : '0;
    assign bus.sram_addr  = data_sel ? bus.data_addr : bus.inst_addr;
    assign bus.sram_wdata = bus.data_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_owner   <= OWNER_NONE;
            resp_read    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (data_sel)
                resp_owner <= OWNER_DATA;
            else if (inst_sel)
                resp_owner <= OWNER_INST;
            else
                resp_owner <= OWNER_NONE;
            resp_read <= data_sel && (bus.data_wen == '0);
            if (inst_rvalid)
                inst_rdata_q <= bus.sram_rdata;
            if (data_rvalid && resp_read)
                data_rdata_q <= bus.sram_rdata;
        end
    end

    assign inst_rvalid = (resp_owner == OWNER_INST);
    assign data_rvalid = (resp_owner == OWNER_DATA);

    // SRAM data arrives in the rvalid cycle, so it is forwarded then and held afterwards.
    assign bus.inst_rvalid = inst_rvalid;
    assign bus.data_rvalid = data_rvalid;
    assign bus.inst_rdata  = inst_rvalid ? bus.sram_rdata : inst_rdata_q;
    assign bus.data_rdata  = (data_rvalid && resp_read) ? bus.sram_rdata : data_rdata_q;

endmodule
